uart_tx_fifo_ctrl: RTL

//  Upstream feeder for the UART transmit datapath. Buffers host-written bytes in a FIFO.

---
 rtl/uart_tx_fifo_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO and frame sequencer feeding the UART transmit datapath.
// Optional inter-frame idle gap enabled by defining UART_TX_GAP_EN.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
`ifdef UART_TX_GAP_EN
  , parameter int unsigned GAP_CYCLES = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             tx_enable,
  input  logic             ovf_clr,
  input  logic             tx_done,
  output logic             tx_start,
  output logic             tx_sel,
  output logic [7:0]       tx_data,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef UART_TX_GAP_EN
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_nxt;
  logic             push_c;
  logic             pop_c;

  // Next-state decode; a pop happens only on the IDLE -> START transition
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_enable && !empty) begin
          pop_c     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: state_nxt = S_SEND;
      S_SEND: begin
        if (tx_done) begin
`ifdef UART_TX_GAP_EN
          state_nxt = S_GAP;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // full is the pre-pop view, so a write colliding with a pop on a full FIFO is dropped
  always_comb begin
    push_c    = wr_en && !full;
    count_nxt = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      tx_sel   <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state_nxt == S_START);
      tx_sel   <= (state_nxt == S_SEND);
      busy     <= (state_nxt != S_IDLE);
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      empty    <= (count_nxt == '0);
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (wr_en && full) overflow <= 1'b1;
      else if (ovf_clr)  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_GAP_EN
  // Preloaded outside GAP so the state lasts exactly GAP_CYCLES clocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= GAP_W'(GAP_CYCLES - 1);
    end else if (state != S_GAP) begin
      gap_cnt <= GAP_W'(GAP_CYCLES - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
`endif

endmodule
